// File: rtl/ctrl_fsm.sv
// ctrl_fsm: hardwired fetch/decode/execute sequencer; clk/reset/run/ir in, datapath strobes + alu_op/halted/state out
module ctrl_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] ir,
  output logic        pc_out,
  output logic        pc_in,
  output logic        inc_pc,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        read,
  output logic        write,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        z_low_out,
  output logic        c_out,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        r_in,
  output logic        r_out,
  output logic        ba_out,
  output logic [3:0]  alu_op,
  output logic        halted,
  output logic [3:0]  state
);
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_T7   = 4'd8;
  localparam logic [3:0] S_HALT = 4'd9;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  logic [3:0] state_q, state_d, next_instr;
  logic [4:0] op;
  logic       unused_ir;
  logic       is_ld, is_ldi, is_st, is_alu, is_halt, is_imm, is_mem;
  logic       t0, t1, t2, t3, t4, t5, t6, t7;
  assign op        = ir[31:27];
  assign unused_ir = ^ir[26:0];
  assign is_ld     = op == OP_LD;
  assign is_ldi    = op == OP_LDI;
  assign is_st     = op == OP_ST;
  assign is_alu    = op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_OR;
  assign is_halt   = op == OP_HALT;
  assign is_imm    = is_ld | is_ldi | is_st;
  assign is_mem    = is_ld | is_st;
  assign next_instr = run ? S_T0 : S_IDLE;
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE: state_d = run ? S_T0 : S_IDLE;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3:   state_d = is_halt ? S_HALT : (is_imm | is_alu) ? S_T4 : next_instr;
      S_T4:   state_d = S_T5;
      S_T5:   state_d = is_mem ? S_T6 : next_instr;
      S_T6:   state_d = S_T7;
      S_T7:   state_d = next_instr;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  assign t0 = state_q == S_T0;
  assign t1 = state_q == S_T1;
  assign t2 = state_q == S_T2;
  assign t3 = state_q == S_T3;
  assign t4 = state_q == S_T4;
  assign t5 = state_q == S_T5;
  assign t6 = state_q == S_T6;
  assign t7 = state_q == S_T7;
  always_comb begin
    pc_out    = t0;
    inc_pc    = t0;
    mar_in    = t0 | (t5 & is_mem);
    z_in      = t0 | (t4 & (is_imm | is_alu));
    pc_in     = t1;
    read      = t1 | (t6 & is_ld);
    mdr_in    = t1 | (t6 & is_mem);
    z_low_out = t1 | (t5 & (is_imm | is_alu));
    mdr_out   = t2 | (t7 & is_ld);
    ir_in     = t2;
    grb       = t3 & (is_imm | is_alu);
    y_in      = t3 & (is_imm | is_alu);
    ba_out    = t3 & is_imm;
    c_out     = t4 & is_imm;
    grc       = t4 & is_alu;
    r_out     = ((t3 | t4) & is_alu) | (t6 & is_st);
    gra       = (t5 & (is_ldi | is_alu)) | (t6 & is_st) | (t7 & is_ld);
    r_in      = (t5 & (is_ldi | is_alu)) | (t7 & is_ld);
    write     = t7 & is_st;
    alu_op    = (t0 | (t4 & is_imm)) ? ALU_ADD :
                !(t4 & is_alu)       ? 4'b0000 :
                op == OP_SUB         ? ALU_SUB :
                op == OP_AND         ? ALU_AND :
                op == OP_OR          ? ALU_OR  : ALU_ADD;
    halted    = state_q == S_HALT;
    state     = state_q;
  end
endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm: directed scoreboard bench for ctrl_fsm
module tb_ctrl_fsm;
  logic        clk = 1'b0;
  logic        reset, run;
  logic [31:0] ir;
  logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, write, ir_in, y_in, z_in;
  logic z_low_out, c_out, gra, grb, grc, r_in, r_out, ba_out, halted;
  logic [3:0] alu_op, state;
  localparam logic [18:0] PC_OUT = 19'd1 << 18;
  localparam logic [18:0] PC_IN  = 19'd1 << 17;
  localparam logic [18:0] INC_PC = 19'd1 << 16;
  localparam logic [18:0] MAR_IN = 19'd1 << 15;
  localparam logic [18:0] MDR_IN = 19'd1 << 14;
  localparam logic [18:0] MDR_OUT = 19'd1 << 13;
  localparam logic [18:0] READ   = 19'd1 << 12;
  localparam logic [18:0] WRITE  = 19'd1 << 11;
  localparam logic [18:0] IR_IN  = 19'd1 << 10;
  localparam logic [18:0] Y_IN   = 19'd1 << 9;
  localparam logic [18:0] Z_IN   = 19'd1 << 8;
  localparam logic [18:0] Z_LOW_OUT = 19'd1 << 7;
  localparam logic [18:0] C_OUT  = 19'd1 << 6;
  localparam logic [18:0] GRA    = 19'd1 << 5;
  localparam logic [18:0] GRB    = 19'd1 << 4;
  localparam logic [18:0] GRC    = 19'd1 << 3;
  localparam logic [18:0] R_IN   = 19'd1 << 2;
  localparam logic [18:0] R_OUT  = 19'd1 << 1;
  localparam logic [18:0] BA_OUT = 19'd1;
  typedef struct packed {
    logic [3:0]  st;
    logic        h;
    logic [3:0]  op;
    logic [18:0] sb;
  } exp_t;
  exp_t exp_q[$];
  int   tag_q[$];
  int   checks = 0, failures = 0, step_no = 0;
  logic mon_en = 1'b0;
  exp_t got, e;
  int   tg;
  ctrl_fsm dut (
    .clk(clk), .reset(reset), .run(run), .ir(ir),
    .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in), .mdr_in(mdr_in),
    .mdr_out(mdr_out), .read(read), .write(write), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
    .z_low_out(z_low_out), .c_out(c_out), .gra(gra), .grb(grb), .grc(grc), .r_in(r_in),
    .r_out(r_out), .ba_out(ba_out), .alu_op(alu_op), .halted(halted), .state(state)
  );
  always #5 clk = ~clk;
  assign got = '{st: state, h: halted, op: alu_op,
                 sb: {pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, write, ir_in, y_in, z_in,
                      z_low_out, c_out, gra, grb, grc, r_in, r_out, ba_out}};
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if ((read & write) !== 1'b0) begin
        failures++;
        $display("FAIL rw_excl read=%b write=%b", read, write);
      end
      checks++;
      if ($countones({pc_out, z_low_out, mdr_out, r_out, ba_out, c_out}) > 1) begin
        failures++;
        $display("FAIL bus_excl drivers=%b required at most one", {pc_out, z_low_out, mdr_out, r_out, ba_out, c_out});
      end
      checks++;
      if ($countones({gra, grb, grc}) > 1) begin
        failures++;
        $display("FAIL gr_excl gra/grb/grc=%b required at most one", {gra, grb, grc});
      end
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        tg = tag_q.pop_front();
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL step%0d got st=%0d h=%b op=%b sb=%b exp st=%0d h=%b op=%b sb=%b",
                   tg, got.st, got.h, got.op, got.sb, e.st, e.h, e.op, e.sb);
        end
      end
    end
  end
  task automatic step(input logic r, input logic [31:0] i, input logic rs,
                      input logic [3:0] st, input logic [18:0] sb, input logic [3:0] op, input logic h);
    run = r; ir = i; reset = rs;
    exp_q.push_back('{st: st, h: h, op: op, sb: sb});
    tag_q.push_back(step_no++);
    @(posedge clk); #1;
  endtask
  task automatic fetch(input logic [31:0] i);
    step(1, i, 0, 4'd1, PC_OUT | MAR_IN | INC_PC | Z_IN, 4'b0010, 0);
    step(1, i, 0, 4'd2, Z_LOW_OUT | PC_IN | READ | MDR_IN, 4'b0000, 0);
    step(1, i, 0, 4'd3, MDR_OUT | IR_IN, 4'b0000, 0);
  endtask
  task automatic alu_instr(input logic [31:0] i, input logic [3:0] op, input logic r4);
    fetch(i);
    step(1, i, 0, 4'd4, GRB | R_OUT | Y_IN, 4'b0000, 0);
    step(r4, i, 0, 4'd5, GRC | R_OUT | Z_IN, op, 0);
    step(r4, i, 0, 4'd6, Z_LOW_OUT | GRA | R_IN, 4'b0000, 0);
  endtask
  task automatic mem_head(input logic [31:0] i);
    fetch(i);
    step(1, i, 0, 4'd4, GRB | BA_OUT | Y_IN, 4'b0000, 0);
    step(1, i, 0, 4'd5, C_OUT | Z_IN, 4'b0010, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    reset = 1'b1; run = 1'b0; ir = 32'h0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    step(0, 32'h0, 0, 4'd0, 19'd0, 4'b0000, 0);
    step(1, 32'h0, 0, 4'd0, 19'd0, 4'b0000, 0);
    mem_head(32'h08800085);
    step(1, 32'h08800085, 0, 4'd6, Z_LOW_OUT | GRA | R_IN, 4'b0000, 0);
    mem_head(32'h00800010);
    step(1, 32'h00800010, 0, 4'd6, Z_LOW_OUT | MAR_IN, 4'b0000, 0);
    step(1, 32'h00800010, 0, 4'd7, READ | MDR_IN, 4'b0000, 0);
    step(1, 32'h00800010, 0, 4'd8, MDR_OUT | GRA | R_IN, 4'b0000, 0);
    mem_head(32'h10800010);
    step(1, 32'h10800010, 0, 4'd6, Z_LOW_OUT | MAR_IN, 4'b0000, 0);
    step(1, 32'h10800010, 0, 4'd7, GRA | R_OUT | MDR_IN, 4'b0000, 0);
    step(1, 32'h10800010, 0, 4'd8, WRITE, 4'b0000, 0);
    alu_instr(32'h20918000, 4'b0011, 1);
    alu_instr(32'h28918000, 4'b0000, 1);
    alu_instr(32'h30918000, 4'b0001, 1);
    alu_instr(32'h18918000, 4'b0010, 0);
    step(0, 32'h0, 0, 4'd0, 19'd0, 4'b0000, 0);
    step(1, 32'h0, 0, 4'd0, 19'd0, 4'b0000, 0);
    fetch(32'hA8000000);
    step(1, 32'hA8000000, 0, 4'd4, 19'd0, 4'b0000, 0);
    mem_head(32'h00800010);
    step(1, 32'h00800010, 0, 4'd6, Z_LOW_OUT | MAR_IN, 4'b0000, 0);
    step(1, 32'h00800010, 1, 4'd7, READ | MDR_IN, 4'b0000, 0);
    step(1, 32'h00800010, 0, 4'd0, 19'd0, 4'b0000, 0);
    fetch(32'hD8000000);
    step(1, 32'hD8000000, 0, 4'd4, 19'd0, 4'b0000, 0);
    for (int k = 0; k < 20; k++) step(1, 32'hD8000000, 0, 4'd9, 19'd0, 4'b0000, 1);
    step(1, 32'hD8000000, 1, 4'd9, 19'd0, 4'b0000, 1);
    step(0, 32'h0, 0, 4'd0, 19'd0, 4'b0000, 0);
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
